traffic_light_monitor: RTL and testbench

//  Receiving-side checker for the intersection lamp bus (M1, M2, MT, S; one-hot 3-bit: 001=GRN, 010=YEL, 100=RED).

---
 rtl/tlm_pkg.sv | 59 +++++
 rtl/tlm_if.sv | 31 +++
 rtl/tlm_lamp_tracker.sv | 82 ++++++++
 rtl/traffic_light_monitor.sv | 138 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlm_pkg.sv
// Shared types for the traffic light monitor: lamp codes, tracker states, error codes.
package tlm_pkg;

    localparam int unsigned LAMP_W     = 3;
    localparam int unsigned ERR_CODE_W = 3;

    typedef logic [LAMP_W-1:0]     lamp_t;
    typedef logic [ERR_CODE_W-1:0] err_code_t;

    localparam lamp_t LAMP_GRN = 3'b001;
    localparam lamp_t LAMP_YEL = 3'b010;
    localparam lamp_t LAMP_RED = 3'b100;

    typedef enum logic [1:0] {
        TRK_UNK = 2'd0,
        TRK_GRN = 2'd1,
        TRK_YEL = 2'd2,
        TRK_RED = 2'd3
    } trk_state_e;

    localparam err_code_t ERR_NONE     = 3'd0;
    localparam err_code_t ERR_CONFLICT = 3'd1;
    localparam err_code_t ERR_ENCODING = 3'd2;
    localparam err_code_t ERR_SEQUENCE = 3'd3;
    localparam err_code_t ERR_TIMING   = 3'd4;
    localparam err_code_t ERR_STUCK    = 3'd5;

    typedef struct packed {
        logic conflict;
        logic encoding;
        logic seq;
        logic timing;
        logic stuck;
    } err_vec_t;

    function automatic logic lamp_legal(lamp_t c);
        return (c == LAMP_GRN) || (c == LAMP_YEL) || (c == LAMP_RED);
    endfunction

    function automatic trk_state_e lamp_to_state(lamp_t c);
        case (c)
            LAMP_GRN: return TRK_GRN;
            LAMP_YEL: return TRK_YEL;
            LAMP_RED: return TRK_RED;
            default:  return TRK_UNK;
        endcase
    endfunction

    // Lowest-numbered error wins when several arrive together.
    function automatic err_code_t first_err(err_vec_t e);
        if (e.conflict) return ERR_CONFLICT;
        if (e.encoding) return ERR_ENCODING;
        if (e.seq)      return ERR_SEQUENCE;
        if (e.timing)   return ERR_TIMING;
        if (e.stuck)    return ERR_STUCK;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/tlm_if.sv
// Lamp bus plus status outputs of the traffic light monitor.
interface tlm_if #(parameter int unsigned CNT_W = 8);
    import tlm_pkg::*;

    lamp_t            light_M1;
    lamp_t            light_M2;
    lamp_t            light_MT;
    lamp_t            light_S;
    logic             clr_err;
    logic             err_conflict;
    logic             err_encoding;
    logic             err_sequence;
    logic             err_timing;
    logic             err_stuck;
    logic             err_any;
    err_code_t        err_code;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output light_M1, light_M2, light_MT, light_S, clr_err,
        input  err_conflict, err_encoding, err_sequence, err_timing, err_stuck,
               err_any, err_code, cycle_count
    );

    modport slave (
        input  light_M1, light_M2, light_MT, light_S, clr_err,
        output err_conflict, err_encoding, err_sequence, err_timing, err_stuck,
               err_any, err_code, cycle_count
    );

endinterface

// File: rtl/tlm_lamp_tracker.sv
// Per-lamp colour tracker: follows G->Y->R->G and reports one-cycle error pulses.
module tlm_lamp_tracker
    import tlm_pkg::*;
#(
    parameter int unsigned YEL_CYCLES = 3,
    parameter int unsigned MIN_GRN    = 5,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  lamp_t      code,
    output trk_state_e state,
    output logic       enc_err,
    output logic       seq_err,
    output logic       tim_err,
    output logic       yel_to_red
);

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0] YEL_DW    = CNT_W'(YEL_CYCLES);
    localparam logic [CNT_W-1:0] GRN_MIN   = CNT_W'(MIN_GRN);

    logic [CNT_W-1:0] dwell;
    logic             exempt;
    trk_state_e       code_st;
    logic             legal;
    logic             fwd;
    logic             leave_tim;
    logic [CNT_W-1:0] dwell_inc;

    always_comb begin
        code_st   = lamp_to_state(code);
        legal     = lamp_legal(code);
        fwd       = (state == TRK_GRN && code_st == TRK_YEL) ||
                    (state == TRK_YEL && code_st == TRK_RED) ||
                    (state == TRK_RED && code_st == TRK_GRN);
        dwell_inc = (dwell == DWELL_MAX) ? dwell : dwell + CNT_W'(1);
        leave_tim = !exempt &&
                    ((state == TRK_YEL && dwell != YEL_DW) ||
                     (state == TRK_GRN && dwell <  GRN_MIN));
    end

    // The dwell adopted out of UNK is marked exempt from all timing checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TRK_UNK;
            dwell      <= '0;
            exempt     <= 1'b0;
            enc_err    <= 1'b0;
            seq_err    <= 1'b0;
            tim_err    <= 1'b0;
            yel_to_red <= 1'b0;
        end else begin
            enc_err    <= 1'b0;
            seq_err    <= 1'b0;
            tim_err    <= 1'b0;
            yel_to_red <= 1'b0;
            if (!legal) begin
                enc_err <= 1'b1;
                state   <= TRK_UNK;
                dwell   <= '0;
                exempt  <= 1'b0;
            end else if (state == TRK_UNK) begin
                state  <= code_st;
                dwell  <= CNT_W'(1);
                exempt <= 1'b1;
            end else if (code_st == state) begin
                dwell <= dwell_inc;
                if (state == TRK_YEL && !exempt && dwell == YEL_DW)
                    tim_err <= 1'b1;
            end else begin
                seq_err    <= !fwd;
                tim_err    <= leave_tim;
                yel_to_red <= (state == TRK_YEL) && (code_st == TRK_RED);
                state      <= code_st;
                dwell      <= CNT_W'(1);
                exempt     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receiving-side checker for the intersection lamp bus with sticky error flags.
// Optional watchdog (err_stuck) built only when TLM_WATCHDOG_EN is defined.
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int unsigned YEL_CYCLES  = 3,
    parameter int unsigned MIN_GRN     = 5,
    parameter int unsigned WDOG_CYCLES = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    tlm_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trk_state_e st_m1, st_m2, st_s;
    logic       enc_m1, enc_m2, enc_s;
    logic       seq_m1, seq_m2, seq_s;
    logic       tim_m1, tim_m2, tim_s;
    logic       y2r_m1, y2r_m2, y2r_s;

    logic       conflict_q;
    logic       mt_enc_q;
    logic       clr_q;
    logic       stuck_q;

    err_vec_t         new_err;
    err_vec_t         flags, flags_d;
    logic             err_any_q;
    err_code_t        err_code, code_d;
    logic [CNT_W-1:0] cycle_count, cc_d;

    tlm_lamp_tracker #(.YEL_CYCLES(YEL_CYCLES), .MIN_GRN(MIN_GRN), .CNT_W(CNT_W)) u_trk_m1 (
        .clk(clk), .rst(rst), .code(bus.light_M1), .state(st_m1),
        .enc_err(enc_m1), .seq_err(seq_m1), .tim_err(tim_m1), .yel_to_red(y2r_m1)
    );

    tlm_lamp_tracker #(.YEL_CYCLES(YEL_CYCLES), .MIN_GRN(MIN_GRN), .CNT_W(CNT_W)) u_trk_m2 (
        .clk(clk), .rst(rst), .code(bus.light_M2), .state(st_m2),
        .enc_err(enc_m2), .seq_err(seq_m2), .tim_err(tim_m2), .yel_to_red(y2r_m2)
    );

    tlm_lamp_tracker #(.YEL_CYCLES(YEL_CYCLES), .MIN_GRN(MIN_GRN), .CNT_W(CNT_W)) u_trk_s (
        .clk(clk), .rst(rst), .code(bus.light_S), .state(st_s),
        .enc_err(enc_s), .seq_err(seq_s), .tim_err(tim_s), .yel_to_red(y2r_s)
    );

    // Tracker states and main-road cycle pulses are kept for debug taps only.
    logic trk_unused;
    assign trk_unused = ^{st_m1, st_m2, st_s, y2r_m1, y2r_m2};

    // First stage aligns raw-input checks and clr_err with the tracker pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
            mt_enc_q   <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            conflict_q <= (bus.light_S != LAMP_RED) &&
                          ((bus.light_M1 != LAMP_RED) || (bus.light_M2 != LAMP_RED));
            mt_enc_q   <= !lamp_legal(bus.light_MT);
            clr_q      <= bus.clr_err;
        end
    end

`ifdef TLM_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_HIT = CNT_W'(WDOG_CYCLES - 1);

    logic [4*LAMP_W-1:0] prev_lamps;
    logic [CNT_W-1:0]    wd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_lamps <= '0;
            wd_cnt     <= '0;
            stuck_q    <= 1'b0;
        end else begin
            prev_lamps <= {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S};
            stuck_q    <= 1'b0;
            if ({bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S} != prev_lamps) begin
                wd_cnt <= '0;
            end else begin
                if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + CNT_W'(1);
                if (wd_cnt == WD_HIT)  stuck_q <= 1'b1;
            end
        end
    end
`else
    localparam int unsigned WDOG_UNUSED = WDOG_CYCLES;
    assign stuck_q = 1'b0;
`endif

    // A new error in the clearing cycle survives the clear.
    always_comb begin
        new_err          = '0;
        new_err.conflict = conflict_q;
        new_err.encoding = enc_m1 | enc_m2 | enc_s | mt_enc_q;
        new_err.seq      = seq_m1 | seq_m2 | seq_s;
        new_err.timing   = tim_m1 | tim_m2 | tim_s;
        new_err.stuck    = stuck_q;

        flags_d = clr_q ? new_err : (flags | new_err);

        code_d = err_code;
        if (clr_q || err_code == ERR_NONE)
            code_d = first_err(new_err);

        cc_d = cycle_count;
        if (y2r_s && cycle_count != CNT_MAX)
            cc_d = cycle_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags       <= '0;
            err_any_q   <= 1'b0;
            err_code    <= ERR_NONE;
            cycle_count <= '0;
        end else begin
            flags       <= flags_d;
            err_any_q   <= |flags_d;
            err_code    <= code_d;
            cycle_count <= cc_d;
        end
    end

    assign bus.err_conflict = flags.conflict;
    assign bus.err_encoding = flags.encoding;
    assign bus.err_sequence = flags.seq;
    assign bus.err_timing   = flags.timing;
    assign bus.err_stuck    = flags.stuck;
    assign bus.err_any      = err_any_q;
    assign bus.err_code     = err_code;
    assign bus.cycle_count  = cycle_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: run-length reference model, directed and random phases.
module tb_traffic_light_monitor;

    localparam int YEL  = 3;
    localparam int MING = 5;
`ifdef TLM_WATCHDOG_EN
    localparam int WDOG = 8;
`else
    localparam int WDOG = 64;
`endif
    localparam int CMAX = 255;

    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] BAD = 3'b011;

    logic clk;
    logic rst;
    int   edge_n;
    int   checks;
    int   errors;

    tlm_if #(.CNT_W(8)) bus ();

    traffic_light_monitor #(
        .YEL_CYCLES(YEL), .MIN_GRN(MING), .WDOG_CYCLES(WDOG), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        edge_n = 0;
        forever begin
            @(posedge clk);
            edge_n++;
        end
    end

    typedef struct {
        int ready;
        bit conf, enc, seq, tim, stk, any;
        int code;
        int cc;
    } exp_t;

    exp_t q[$];

    // Reference model: colour 0=unknown 1=green 2=yellow 3=red, plus run length of that colour.
    int         col[3];
    int         run[3];
    bit         ex[3];
    bit         f_conf, f_enc, f_seq, f_tim, f_stk;
    int         code;
    int         cc;
    logic [11:0] wd_prev;
    int         wd_cnt;

    function automatic int colour_of(logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] code_of(int c);
        case (c)
            1:       return G;
            2:       return Y;
            default: return R;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            col[i] = 0; run[i] = 0; ex[i] = 0;
        end
        f_conf = 0; f_enc = 0; f_seq = 0; f_tim = 0; f_stk = 0;
        code = 0; cc = 0; wd_prev = '0; wd_cnt = 0;
    endtask

    task automatic model_lamp(input int i, input logic [2:0] c,
                              output bit e, output bit sq, output bit tm, output bit yr);
        int n;
        n = colour_of(c);
        e = 0; sq = 0; tm = 0; yr = 0;
        if (n == 0) begin
            e = 1; col[i] = 0; run[i] = 0; ex[i] = 0;
        end else if (col[i] == 0) begin
            col[i] = n; run[i] = 1; ex[i] = 1;
        end else if (n == col[i]) begin
            if (run[i] < CMAX) run[i]++;
            if (col[i] == 2 && !ex[i] && run[i] == YEL + 1) tm = 1;
        end else begin
            sq = (n != (col[i] % 3) + 1);
            tm = !ex[i] && ((col[i] == 2 && run[i] != YEL) || (col[i] == 1 && run[i] < MING));
            yr = (col[i] == 2 && n == 3);
            col[i] = n; run[i] = 1; ex[i] = 0;
        end
    endtask

    task automatic model_step(input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt,
                              input logic [2:0] s, input bit clr, output exp_t e);
        bit e0, e1, e2, s0, s1, s2, t0, t1, t2, y0, y1, y2;
        bit pc, pe, ps, pt, pk;
        int first;
        model_lamp(0, m1, e0, s0, t0, y0);
        model_lamp(1, m2, e1, s1, t1, y1);
        model_lamp(2, s,  e2, s2, t2, y2);
        pc = (s != R) && (m1 != R || m2 != R);
        pe = e0 | e1 | e2 | (colour_of(mt) == 0);
        ps = s0 | s1 | s2;
        pt = t0 | t1 | t2;
        pk = 0;
`ifdef TLM_WATCHDOG_EN
        if ({m1, m2, mt, s} == wd_prev) begin
            if (wd_cnt < CMAX) wd_cnt++;
            if (wd_cnt == WDOG) pk = 1;
        end else begin
            wd_cnt = 0;
        end
        wd_prev = {m1, m2, mt, s};
`endif
        first = pc ? 1 : pe ? 2 : ps ? 3 : pt ? 4 : pk ? 5 : 0;
        if (clr) begin
            f_conf = pc; f_enc = pe; f_seq = ps; f_tim = pt; f_stk = pk;
            code = first;
        end else begin
            f_conf |= pc; f_enc |= pe; f_seq |= ps; f_tim |= pt; f_stk |= pk;
            if (code == 0) code = first;
        end
        if (y2 && cc < CMAX) cc++;
        e.conf = f_conf; e.enc = f_enc; e.seq = f_seq; e.tim = f_tim; e.stk = f_stk;
        e.any  = f_conf | f_enc | f_seq | f_tim | f_stk;
        e.code = code;
        e.cc   = cc;
    endtask

    function automatic exp_t zero_exp(int rdy);
        exp_t z;
        z.ready = rdy;
        z.conf = 0; z.enc = 0; z.seq = 0; z.tim = 0; z.stk = 0; z.any = 0;
        z.code = 0; z.cc = 0;
        return z;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, edge_n);
        end
    endtask

    // Monitor: compares the DUT against the entry due at this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0 && q[0].ready == edge_n) begin
                e = q.pop_front();
                chk("err_conflict", 8'(bus.err_conflict), 8'(e.conf));
                chk("err_encoding", 8'(bus.err_encoding), 8'(e.enc));
                chk("err_sequence", 8'(bus.err_sequence), 8'(e.seq));
                chk("err_timing",   8'(bus.err_timing),   8'(e.tim));
                chk("err_stuck",    8'(bus.err_stuck),    8'(e.stk));
                chk("err_any",      8'(bus.err_any),      8'(e.any));
                chk("err_code",     8'(bus.err_code),     8'(e.code));
                chk("cycle_count",  bus.cycle_count,      8'(e.cc));
            end
        end
    end

    task automatic step(input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt,
                        input logic [2:0] s, input bit clr, input bit r);
        exp_t e;
        @(negedge clk);
        bus.light_M1 = m1; bus.light_M2 = m2; bus.light_MT = mt; bus.light_S = s;
        bus.clr_err  = clr;
        rst          = r;
        if (r) begin
            model_reset();
            foreach (q[k]) if (q[k].ready == edge_n + 1) q[k] = zero_exp(edge_n + 1);
            q.push_back(zero_exp(edge_n + 2));
        end else begin
            model_step(m1, m2, mt, s, clr, e);
            e.ready = edge_n + 2;
            q.push_back(e);
        end
    endtask

    task automatic hold(input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt,
                        input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) step(m1, m2, mt, s, 1'b0, 1'b0);
    endtask

    // Controller pattern of period 32: M1 G21/Y3/R8, M2 G11/Y3/R18, S R24/G5/Y3.
    task automatic legal_pattern(input int n);
        int t;
        logic [2:0] m1, m2, s;
        for (int i = 0; i < n; i++) begin
            t  = i % 32;
            m1 = (t < 21) ? G : (t < 24) ? Y : R;
            m2 = (t < 11) ? G : (t < 14) ? Y : R;
            s  = (t < 24) ? R : (t < 29) ? G : Y;
            step(m1, m2, R, s, 1'b0, 1'b0);
        end
    endtask

    // Randomised controller periods with occasional corrupted samples, clears and resets.
    task automatic random_periods(input int periods);
        int gm2, ym2, xtra, ym1, gs, ys, l1g, total;
        logic [2:0] m1, m2, mt, s;
        bit clr, r;
        for (int p = 0; p < periods; p++) begin
            gm2  = $urandom_range(3, 12);
            ym2  = $urandom_range(2, 4);
            xtra = $urandom_range(0, 8);
            ym1  = $urandom_range(2, 4);
            gs   = $urandom_range(3, 7);
            ys   = $urandom_range(2, 4);
            l1g  = gm2 + ym2 + xtra;
            total = l1g + ym1 + gs + ys;
            for (int t = 0; t < total; t++) begin
                m1 = (t < l1g) ? G : (t < l1g + ym1) ? Y : R;
                m2 = (t < gm2) ? G : (t < gm2 + ym2) ? Y : R;
                s  = (t < l1g + ym1) ? R : (t < l1g + ym1 + gs) ? G : Y;
                mt = code_of($urandom_range(1, 3));
                if ($urandom_range(0, 24) == 0) m1 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 24) == 0) m2 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 24) == 0) s  = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 24) == 0) mt = 3'($urandom_range(0, 7));
                clr = ($urandom_range(0, 9) == 0);
                r   = ($urandom_range(0, 299) == 0);
                step(m1, m2, mt, s, clr, r);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.light_M1 = R; bus.light_M2 = R; bus.light_MT = R; bus.light_S = R;
        bus.clr_err = 1'b0;
        model_reset();

        step(R, R, R, R, 1'b0, 1'b1);
        step(R, R, R, R, 1'b0, 1'b1);

        // Three full legal signal cycles.
        legal_pattern(97);

        // Single-cycle conflict, then clear.
        step(G, G, R, G, 1'b0, 1'b0);
        hold(G, G, R, R, 4);
        step(G, G, R, R, 1'b1, 1'b0);
        hold(G, G, R, R, 3);

        // Encoding on M2 together with M1 G->R.
        step(R, BAD, R, R, 1'b0, 1'b0);
        hold(R, R, R, R, 3);
        step(R, R, R, R, 1'b1, 1'b0);

        // Short yellow, then overlong yellow on S.
        hold(R, R, R, G, 6);
        hold(R, R, R, Y, 2);
        hold(R, R, R, R, 3);
        step(R, R, R, R, 1'b1, 1'b0);
        hold(R, R, R, G, 6);
        hold(R, R, R, Y, 4);
        hold(R, R, R, R, 2);
        step(R, R, R, R, 1'b1, 1'b0);
        hold(R, R, R, R, 2);

        // Clear coinciding with a new conflict, then reset mid-run.
        step(G, R, R, G, 1'b1, 1'b0);
        hold(G, R, R, G, 2);
        step(G, R, R, G, 1'b0, 1'b1);
        hold(G, G, R, R, 6);

        // Frozen inputs for the watchdog.
        hold(G, G, R, R, 70);
        step(G, G, R, R, 1'b1, 1'b0);
        hold(G, G, R, R, 2);

        random_periods(20);

        repeat (4) @(negedge clk);
        chk("scoreboard_drain", 8'(q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
